fft_r4_digitrev_serializer: RTL and testbench



---
 rtl/fft_r4_digitrev_serializer.sv | 105 ++++++++++
 tb/tb_fft_r4_digitrev_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_r4_digitrev_serializer.sv
// Ping-pong buffered serializer: takes a packed N_POINT-lane complex vector and streams it
// out one sample per beat in natural order (base-4 digit reversal undone).
// Optional build macro FFT_SER_CONJ_EN: negate output imag with saturation (IFFT via conjugation).
module fft_r4_digitrev_serializer #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned N_POINT    = 16,
  localparam int unsigned IDX_W     = $clog2(N_POINT)
) (
  input  logic                           sys_clk_i,
  input  logic                           rst_i,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  input  logic [DATA_WIDTH*N_POINT-1:0]  s_real_i,
  input  logic [DATA_WIDTH*N_POINT-1:0]  s_imag_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [DATA_WIDTH-1:0]          m_real_o,
  output logic [DATA_WIDTH-1:0]          m_imag_o,
  output logic [IDX_W-1:0]               m_index_o,
  output logic                           m_last_o
);

  if (N_POINT < 4 || (N_POINT & (N_POINT - 1)) != 0 || (IDX_W % 2) != 0) begin : g_bad_n_point
    $error("N_POINT must be a power of 4 and >= 4");
  end

  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_POINT - 1);

  word_t            re_q [2][N_POINT];
  word_t            im_q [2][N_POINT];
  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, rd_sel_q;
  logic [IDX_W-1:0] cnt_q, lane;
  logic             wr_fire, rd_fire, cnt_last;
  word_t            stored_re, stored_im, im_out;

  assign s_ready_o = ~full_q[wr_sel_q];
  assign m_valid_o = full_q[rd_sel_q];
  assign wr_fire   = s_valid_i & s_ready_o;
  assign rd_fire   = m_valid_o & m_ready_i;
  assign cnt_last  = (cnt_q == LastIdx);

  // Base-4 digit reversal: digit d of the lane is digit (IDX_W/2-1-d) of the bin index.
  always_comb begin
    lane = '0;
    for (int d = 0; d < int'(IDX_W / 2); d++) begin
      lane[2*d +: 2] = cnt_q[int'(IDX_W) - 2 - 2*d +: 2];
    end
  end

  always_comb begin
    full_d = full_q;
    if (rd_fire && cnt_last) full_d[rd_sel_q] = 1'b0;
    if (wr_fire)             full_d[wr_sel_q] = 1'b1;
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      full_q <= full_d;
      if (wr_fire) wr_sel_q <= ~wr_sel_q;
      if (rd_fire) begin
        if (cnt_last) begin
          rd_sel_q <= ~rd_sel_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Bank storage is deliberately not reset; the full flags gate every read.
  always_ff @(posedge sys_clk_i) begin
    if (wr_fire) begin
      for (int j = 0; j < int'(N_POINT); j++) begin
        re_q[wr_sel_q][j] <= s_real_i[j*DATA_WIDTH +: DATA_WIDTH];
        im_q[wr_sel_q][j] <= s_imag_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign stored_re = re_q[rd_sel_q][lane];
  assign stored_im = im_q[rd_sel_q][lane];

`ifdef FFT_SER_CONJ_EN
  localparam word_t MinVal = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
  localparam word_t MaxVal = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  assign im_out = (stored_im == MinVal) ? MaxVal : word_t'(-stored_im);
`else
  assign im_out = stored_im;
`endif

  assign m_real_o  = m_valid_o ? stored_re : '0;
  assign m_imag_o  = m_valid_o ? im_out : '0;
  assign m_index_o = cnt_q;
  assign m_last_o  = m_valid_o & cnt_last;

endmodule

// File: tb/tb_fft_r4_digitrev_serializer.sv
// Directed bench for fft_r4_digitrev_serializer: N=16 instance for ordering, back-pressure,
// ping-pong and reset; N=4 instance for the identity-reversal case.
module tb_fft_r4_digitrev_serializer;
  localparam int DW = 18;
  localparam int N  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, s_valid, s_ready, m_valid, m_ready, m_last;
  logic [DW*N-1:0]   s_real, s_imag;
  logic [DW-1:0]     m_real, m_imag;
  logic [3:0]        m_index;

  logic              s_valid4, s_ready4, m_valid4, m_ready4, m_last4;
  logic [DW*4-1:0]   s_real4, s_imag4;
  logic [DW-1:0]     m_real4, m_imag4;
  logic [1:0]        m_index4;

  fft_r4_digitrev_serializer #(.DATA_WIDTH(DW), .N_POINT(N)) dut (
    .sys_clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_real_i(s_real), .s_imag_i(s_imag), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_real_o(m_real), .m_imag_o(m_imag), .m_index_o(m_index), .m_last_o(m_last)
  );

  fft_r4_digitrev_serializer #(.DATA_WIDTH(DW), .N_POINT(4)) dut4 (
    .sys_clk_i(clk), .rst_i(rst), .s_valid_i(s_valid4), .s_ready_o(s_ready4),
    .s_real_i(s_real4), .s_imag_i(s_imag4), .m_valid_o(m_valid4), .m_ready_i(m_ready4),
    .m_real_o(m_real4), .m_imag_o(m_imag4), .m_index_o(m_index4), .m_last_o(m_last4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] w18(input int v);
    logic [DW-1:0] t;
    t = DW'(v);
    return 32'(t);
  endfunction

  // Expected output imag for a stored value v in the current build.
  function automatic logic [31:0] im_exp(input int v);
    logic [DW-1:0] t;
    t = DW'(v);
`ifdef FFT_SER_CONJ_EN
    if (t == 18'h20000) t = 18'h1ffff;
    else t = DW'(-v);
`endif
    return 32'(t);
  endfunction

  function automatic int lane16(input int k);
    return (k % 4) * 4 + k / 4;
  endfunction

  int t1_order [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

  initial begin
    int vin, b, l;
    logic hs;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_real = '0; s_imag = '0;
    s_valid4 = 1'b0; m_ready4 = 1'b0; s_real4 = '0; s_imag4 = '0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last",  32'(m_last),  32'd0);
    chk("rst_m_index", 32'(m_index), 32'd0);
    chk("rst_m_real",  32'(m_real),  32'd0);
    chk("rst_m_imag",  32'(m_imag),  32'd0);
    chk("rst4_valid",  32'(m_valid4), 32'd0);

    // Test 1: real j, imag -j, natural-order readout
    for (int j = 0; j < N; j++) begin
      s_real[j*DW +: DW] = DW'(j);
      s_imag[j*DW +: DW] = DW'(-j);
    end
    s_valid = 1'b1; m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("t1_valid", 32'(m_valid), 32'd1);
      chk("t1_real",  32'(m_real),  w18(t1_order[k]));
      chk("t1_imag",  32'(m_imag),  im_exp(-t1_order[k]));
      chk("t1_index", 32'(m_index), 32'(k));
      chk("t1_last",  32'(m_last),  32'(k == N - 1));
      step();
    end
    chk("t1_done_valid", 32'(m_valid), 32'd0);

    // Test 2: three back-to-back vectors, s_valid held while vectors remain
    vin = 0;
    for (int i = 0; i < 50; i++) begin
      if (i <= 33) chk("t2_s_ready", 32'(s_ready), 32'(i == 0 || i == 1 || i == 17 || i == 33));
      if (i >= 1 && i <= 48) begin
        b = i - 1;
        l = lane16(b % N);
        chk("t2_valid", 32'(m_valid), 32'd1);
        chk("t2_real",  32'(m_real),  w18(100 * (b / N) + l));
        chk("t2_imag",  32'(m_imag),  im_exp(1000 * (b / N) + l));
        chk("t2_index", 32'(m_index), 32'(b % N));
        chk("t2_last",  32'(m_last),  32'((b % N) == N - 1));
      end else begin
        chk("t2_idle_valid", 32'(m_valid), 32'd0);
      end
      s_valid = (vin < 3);
      for (int j = 0; j < N; j++) begin
        s_real[j*DW +: DW] = DW'(100 * vin + j);
        s_imag[j*DW +: DW] = DW'(1000 * vin + j);
      end
      hs = s_valid & s_ready;
      step();
      if (hs) vin++;
    end
    s_valid = 1'b0;
    chk("t2_accepted", 32'(vin), 32'd3);

    // Test 3: m_ready toggling, output must hold through stalls
    m_ready = 1'b0;
    for (int j = 0; j < N; j++) begin
      s_real[j*DW +: DW] = DW'(50 + j);
      s_imag[j*DW +: DW] = DW'(2 * j);
    end
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    b = 0;
    for (int cyc = 0; cyc < 60 && b < N; cyc++) begin
      l = lane16(b);
      chk("t3_valid", 32'(m_valid), 32'd1);
      chk("t3_real",  32'(m_real),  w18(50 + l));
      chk("t3_imag",  32'(m_imag),  im_exp(2 * l));
      chk("t3_index", 32'(m_index), 32'(b));
      chk("t3_last",  32'(m_last),  32'(b == N - 1));
      m_ready = ((cyc % 2) == 0);
      if (m_valid && m_ready) b++;
      step();
    end
    chk("t3_beats", 32'(b), 32'(N));
    chk("t3_done_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;

    // Test 4: reset at beat 5 of vector 0 with vector 1 buffered
    for (int j = 0; j < N; j++) begin
      s_real[j*DW +: DW] = DW'(300 + j);
      s_imag[j*DW +: DW] = DW'(j);
    end
    s_valid = 1'b1;
    step();
    step();
    s_valid = 1'b0;
    step(); step(); step(); step();
    chk("t4_pre_index", 32'(m_index), 32'd5);
    chk("t4_pre_s_ready", 32'(s_ready), 32'd0);
    rst = 1'b1;
    step();
    chk("t4_rst_valid", 32'(m_valid), 32'd0);
    chk("t4_rst_s_ready", 32'(s_ready), 32'd1);
    chk("t4_rst_index", 32'(m_index), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("t4_no_stale", 32'(m_valid), 32'd0);
      step();
    end

    // Test 5: most negative imag on lane 3 -> appears at bin 12
    for (int j = 0; j < N; j++) begin
      s_real[j*DW +: DW] = DW'(j);
      s_imag[j*DW +: DW] = (j == 3) ? DW'(-131072) : DW'(j);
    end
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      l = lane16(k);
      chk("t5_real", 32'(m_real), w18(l));
      chk("t5_imag", 32'(m_imag), im_exp((l == 3) ? -131072 : l));
      step();
    end
    chk("t5_done_valid", 32'(m_valid), 32'd0);

    // Test 6: N_POINT=4, reversal is the identity
    for (int j = 0; j < 4; j++) begin
      s_real4[j*DW +: DW] = DW'(10 * (j + 1));
      s_imag4[j*DW +: DW] = DW'(j + 1);
    end
    chk("t6_s_ready", 32'(s_ready4), 32'd1);
    s_valid4 = 1'b1; m_ready4 = 1'b1;
    step();
    s_valid4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t6_valid", 32'(m_valid4), 32'd1);
      chk("t6_real",  32'(m_real4),  w18(10 * (k + 1)));
      chk("t6_imag",  32'(m_imag4),  im_exp(k + 1));
      chk("t6_index", 32'(m_index4), 32'(k));
      chk("t6_last",  32'(m_last4),  32'(k == 3));
      step();
    end
    chk("t6_done_valid", 32'(m_valid4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
